ahb_dut: RTL and testbench

AHB_DUT -- requirements
Module: ahb_dut

---
 rtl/ahb_pkg.sv | 45 ++++
 rtl/ahb_arbiter.sv | 54 +++++
 rtl/ahb_dut.sv | 162 ++++++++++++++++
 tb/tb_ahb_dut.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, bus widths, default port counts and the address decoder
// used by the shared-bus interconnect.
package ahb_pkg;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int MAS_NUM = 4;
    localparam int SLV_NUM = 7;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic {
        HRESP_OKAY  = 1'b0,
        HRESP_ERROR = 1'b1
    } hresp_e;

    typedef enum logic [1:0] {
        DS_IDLE,
        DS_ERR1,
        DS_ERR2
    } ds_state_e;

    typedef struct packed {
        logic       dflt;
        logic [3:0] idx;
    } dec_t;

    // The top address nibble picks the slave; nibbles beyond the populated range go to the default slave.
    function automatic dec_t addr_decode(input logic [ADDR_W-1:0] addr, input int slv_num);
        dec_t d;
        d.idx  = addr[ADDR_W-1 -: 4];
        d.dflt = (int'({28'd0, d.idx}) >= slv_num);
        return d;
    endfunction

    function automatic logic trans_active(input logic [1:0] t);
        return (t == HTRANS_NONSEQ) || (t == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/ahb_arbiter.sv
// Round-robin address-bus arbiter: ownership moves only when the current owner is idle
// and the bus is ready; with no other requester the bus stays parked on the owner.
module ahb_arbiter
    import ahb_pkg::*;
#(
    parameter  int MasNum = MAS_NUM,
    localparam int OwnW   = (MasNum > 1) ? $clog2(MasNum) : 1
) (
    input  logic              hclk,
    input  logic              hreset_n,
    input  logic [MasNum-1:0] req,
    input  logic              bus_release,
    input  logic              hready,
    output logic [OwnW-1:0]   owner
);

    logic [OwnW-1:0] owner_q;
    logic [OwnW-1:0] owner_d;
    logic [OwnW-1:0] cand_idx;
    logic            found;
    int              cand;

    // Search starts just after the current owner so every master gets a fair turn.
    always_comb begin
        owner_d  = owner_q;
        found    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        if (hready && bus_release) begin
            for (int i = 1; i < MasNum; i++) begin
                cand = int'(owner_q) + i;
                if (cand >= MasNum) begin
                    cand = cand - MasNum;
                end
                cand_idx = OwnW'(cand);
                if (!found && req[cand_idx]) begin
                    owner_d = cand_idx;
                    found   = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            owner_q <= '0;
        end else begin
            owner_q <= owner_d;
        end
    end

    assign owner = owner_q;

endmodule

// File: rtl/ahb_dut.sv
// Single shared-bus AHB-Lite interconnect: one address owner broadcasts to all slaves,
// the registered data-phase target steers read data, responses and ready back to masters.
module ahb_dut
    import ahb_pkg::*;
#(
    parameter  int MasNum = MAS_NUM,
    parameter  int SlvNum = SLV_NUM,
    localparam int OwnW   = (MasNum > 1) ? $clog2(MasNum) : 1
) (
    input  logic                          hclk,
    input  logic                          hreset_n,
    input  logic [MasNum-1:0][ADDR_W-1:0] m_haddr,
    input  logic [MasNum-1:0][1:0]        m_htrans,
    input  logic [MasNum-1:0]             m_hwrite,
    input  logic [MasNum-1:0][2:0]        m_hsize,
    input  logic [MasNum-1:0][2:0]        m_hburst,
    input  logic [MasNum-1:0][3:0]        m_hprot,
    input  logic [MasNum-1:0][DATA_W-1:0] m_hwdata,
    output logic [MasNum-1:0][DATA_W-1:0] m_hrdata,
    output logic [MasNum-1:0]             m_hready,
    output logic [MasNum-1:0]             m_hresp,
    output logic [SlvNum-1:0]             s_hsel,
    output logic [SlvNum-1:0][ADDR_W-1:0] s_haddr,
    output logic [SlvNum-1:0][1:0]        s_htrans,
    output logic [SlvNum-1:0]             s_hwrite,
    output logic [SlvNum-1:0][2:0]        s_hsize,
    output logic [SlvNum-1:0][2:0]        s_hburst,
    output logic [SlvNum-1:0][3:0]        s_hprot,
    output logic [SlvNum-1:0][DATA_W-1:0] s_hwdata,
    output logic [SlvNum-1:0]             s_hreadyin,
    input  logic [SlvNum-1:0][DATA_W-1:0] s_hrdata,
    input  logic [SlvNum-1:0]             s_hreadyout,
    input  logic [SlvNum-1:0]             s_hresp
);

    logic [OwnW-1:0]   aown;
    logic [MasNum-1:0] req_vec;
    logic [1:0]        a_trans;
    logic              a_active;
    dec_t              a_dec;

    logic              bus_hready;
    logic              ds_hready;
    logic              ds_hresp;
    logic              sel_readyout;
    logic              sel_resp;
    logic [DATA_W-1:0] sel_rdata;
    logic [DATA_W-1:0] dp_rdata;
    logic              dp_resp;

    logic              dp_valid_q, dp_valid_d;
    logic              dp_dflt_q,  dp_dflt_d;
    logic [3:0]        dp_slv_q,   dp_slv_d;
    logic [OwnW-1:0]   dp_down_q,  dp_down_d;
    ds_state_e         ds_q,       ds_d;

    assign a_trans  = m_htrans[aown];
    assign a_active = trans_active(a_trans);
    assign a_dec    = addr_decode(m_haddr[aown], SlvNum);

    always_comb begin
        req_vec = '0;
        for (int i = 0; i < MasNum; i++) begin
            req_vec[i] = (m_htrans[i] == HTRANS_NONSEQ);
        end
    end

    ahb_arbiter #(.MasNum(MasNum)) u_arbiter (
        .hclk        (hclk),
        .hreset_n    (hreset_n),
        .req         (req_vec),
        .bus_release (a_trans == HTRANS_IDLE),
        .hready      (bus_hready),
        .owner       (aown)
    );

    always_comb begin
        sel_readyout = 1'b1;
        sel_rdata    = '0;
        sel_resp     = HRESP_OKAY;
        for (int k = 0; k < SlvNum; k++) begin
            if (dp_slv_q == 4'(k)) begin
                sel_readyout = s_hreadyout[k];
                sel_rdata    = s_hrdata[k];
                sel_resp     = s_hresp[k];
            end
        end
    end

    assign ds_hready  = (ds_q != DS_ERR1);
    assign ds_hresp   = (ds_q != DS_IDLE);
    assign bus_hready = !dp_valid_q ? 1'b1 : (dp_dflt_q ? ds_hready : sel_readyout);
    assign dp_rdata   = (dp_valid_q && !dp_dflt_q) ? sel_rdata : '0;
    assign dp_resp    = dp_valid_q ? (dp_dflt_q ? ds_hresp : sel_resp) : HRESP_OKAY;

    // Write data follows the data-phase owner, which may already differ from the address owner.
    always_comb begin
        for (int k = 0; k < SlvNum; k++) begin
            s_hsel[k]     = a_active && !a_dec.dflt && (a_dec.idx == 4'(k));
            s_haddr[k]    = m_haddr[aown];
            s_htrans[k]   = a_trans;
            s_hwrite[k]   = m_hwrite[aown];
            s_hsize[k]    = m_hsize[aown];
            s_hburst[k]   = m_hburst[aown];
            s_hprot[k]    = m_hprot[aown];
            s_hwdata[k]   = dp_valid_q ? m_hwdata[dp_down_q] : m_hwdata[aown];
            s_hreadyin[k] = bus_hready;
        end
    end

    always_comb begin
        for (int i = 0; i < MasNum; i++) begin
            m_hrdata[i] = dp_rdata;
            m_hresp[i]  = (dp_valid_q && (dp_down_q == OwnW'(i))) ? dp_resp : HRESP_OKAY;
            if ((aown == OwnW'(i)) || (dp_valid_q && (dp_down_q == OwnW'(i)))) begin
                m_hready[i] = bus_hready;
            end else begin
                m_hready[i] = !trans_active(m_htrans[i]);
            end
        end
    end

    // The default slave walks its own two-cycle error even though it holds bus hready low.
    always_comb begin
        dp_valid_d = dp_valid_q;
        dp_dflt_d  = dp_dflt_q;
        dp_slv_d   = dp_slv_q;
        dp_down_d  = dp_down_q;
        ds_d       = ds_q;
        if (bus_hready) begin
            dp_valid_d = a_active;
            dp_dflt_d  = a_dec.dflt;
            dp_slv_d   = a_dec.idx;
            dp_down_d  = aown;
        end
        case (ds_q)
            DS_ERR1: ds_d = DS_ERR2;
            default: begin
                if (bus_hready) begin
                    ds_d = (a_active && a_dec.dflt) ? DS_ERR1 : DS_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            dp_valid_q <= 1'b0;
            dp_dflt_q  <= 1'b0;
            dp_slv_q   <= '0;
            dp_down_q  <= '0;
            ds_q       <= DS_IDLE;
        end else begin
            dp_valid_q <= dp_valid_d;
            dp_dflt_q  <= dp_dflt_d;
            dp_slv_q   <= dp_slv_d;
            dp_down_q  <= dp_down_d;
            ds_q       <= ds_d;
        end
    end

endmodule

// File: tb/tb_ahb_dut.sv
// Testbench for ahb_dut: directed bus scenarios followed by randomized request rounds
// checked against a transaction-level model of grant order and data routing.
module tb_ahb_dut;

    localparam int MAS = 4;
    localparam int SLV = 7;
    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_NONSEQ = 2'b10;
    localparam logic [1:0] T_SEQ    = 2'b11;

    logic hclk = 1'b0;
    logic hreset_n = 1'b0;

    logic [MAS-1:0][31:0] m_haddr, m_hwdata, m_hrdata;
    logic [MAS-1:0][1:0]  m_htrans;
    logic [MAS-1:0]       m_hwrite, m_hready, m_hresp;
    logic [MAS-1:0][2:0]  m_hsize, m_hburst;
    logic [MAS-1:0][3:0]  m_hprot;

    logic [SLV-1:0]       s_hsel, s_hwrite, s_hreadyin, s_hreadyout, s_hresp;
    logic [SLV-1:0][31:0] s_haddr, s_hwdata, s_hrdata;
    logic [SLV-1:0][1:0]  s_htrans;
    logic [SLV-1:0][2:0]  s_hsize, s_hburst;
    logic [SLV-1:0][3:0]  s_hprot;

    int n_cmp = 0;
    int n_fail = 0;

    int          st [MAS];
    logic [31:0] ad [MAS];
    logic [31:0] wd [MAS];
    logic        wr [MAS];
    bit          acc[MAS];
    bit          fin[MAS];
    int          exp_q[$];
    int          got_q[$];
    int          owner_m;
    int          pending;
    int          cyc;
    int          sl;
    logic [3:0]  mask;

    ahb_dut #(.MasNum(MAS), .SlvNum(SLV)) dut (
        .hclk        (hclk),
        .hreset_n    (hreset_n),
        .m_haddr     (m_haddr),
        .m_htrans    (m_htrans),
        .m_hwrite    (m_hwrite),
        .m_hsize     (m_hsize),
        .m_hburst    (m_hburst),
        .m_hprot     (m_hprot),
        .m_hwdata    (m_hwdata),
        .m_hrdata    (m_hrdata),
        .m_hready    (m_hready),
        .m_hresp     (m_hresp),
        .s_hsel      (s_hsel),
        .s_haddr     (s_haddr),
        .s_htrans    (s_htrans),
        .s_hwrite    (s_hwrite),
        .s_hsize     (s_hsize),
        .s_hburst    (s_hburst),
        .s_hprot     (s_hprot),
        .s_hwdata    (s_hwdata),
        .s_hreadyin  (s_hreadyin),
        .s_hrdata    (s_hrdata),
        .s_hreadyout (s_hreadyout),
        .s_hresp     (s_hresp)
    );

    always #5 hclk = ~hclk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input int m, input logic [1:0] trans, input logic [31:0] addr,
                                 input logic write, input logic [31:0] wdata);
        m_htrans[m] = trans;
        m_haddr[m]  = addr;
        m_hwrite[m] = write;
        m_hwdata[m] = wdata;
    endtask

    task automatic nextCycle();
        @(posedge hclk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not reach the summary");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        $display("[TB] start");
        m_haddr = '0; m_htrans = '0; m_hwrite = '0; m_hwdata = '0; m_hburst = '0;
        m_hsize = {MAS{3'b010}};
        m_hprot = {MAS{4'b0011}};
        s_hreadyout = '1;
        s_hresp = '1;
        for (int k = 0; k < SLV; k++) s_hrdata[k] = 32'hDEAD_0000 + 32'(k);

        // Reset state: master 0 owns, no data phase, responses blocked.
        applyStimulus(0, T_NONSEQ, 32'h3000_0010, 1'b0, 32'h0);
        @(negedge hclk);
        checkOutput("rst_hready", 32'(m_hready), 32'hF);
        checkOutput("rst_hresp", 32'(m_hresp), 32'h0);
        checkOutput("rst_hrdata", m_hrdata[0], 32'h0);
        checkOutput("rst_hsel", 32'(s_hsel), 32'h08);
        checkOutput("rst_hreadyin", 32'(s_hreadyin), 32'h7F);
        nextCycle();
        applyStimulus(0, T_IDLE, 32'h0, 1'b0, 32'h0);
        s_hresp = '0;
        s_hrdata = '0;
        hreset_n = 1'b1;
        nextCycle();

        // Zero-wait write from master 0 to slave 1.
        applyStimulus(0, T_NONSEQ, 32'h1000_0004, 1'b1, 32'h0);
        @(negedge hclk);
        checkOutput("wr_hsel", 32'(s_hsel), 32'h02);
        checkOutput("wr_hready_a", 32'(m_hready[0]), 32'h1);
        checkOutput("wr_haddr", s_haddr[4], 32'h1000_0004);
        checkOutput("wr_hwrite", 32'(s_hwrite[1]), 32'h1);
        nextCycle();
        applyStimulus(0, T_IDLE, 32'h1000_0004, 1'b1, 32'hA5A5_A5A5);
        @(negedge hclk);
        checkOutput("wr_hsel_off", 32'(s_hsel), 32'h0);
        checkOutput("wr_hwdata", s_hwdata[1], 32'hA5A5_A5A5);
        checkOutput("wr_hready_d", 32'(m_hready[0]), 32'h1);
        checkOutput("wr_hresp", 32'(m_hresp[0]), 32'h0);
        nextCycle();

        // Master 2 read from slave 6 with two wait states.
        applyStimulus(2, T_NONSEQ, 32'h6000_0000, 1'b0, 32'h0);
        @(negedge hclk);
        checkOutput("rd_stall", 32'(m_hready[2]), 32'h0);
        checkOutput("rd_nosel", 32'(s_hsel), 32'h0);
        nextCycle();
        @(negedge hclk);
        checkOutput("rd_hsel", 32'(s_hsel), 32'h40);
        checkOutput("rd_hready_a", 32'(m_hready[2]), 32'h1);
        nextCycle();
        applyStimulus(2, T_IDLE, 32'h6000_0000, 1'b0, 32'h0);
        s_hreadyout[6] = 1'b0;
        s_hrdata[6] = 32'h1234_5678;
        @(negedge hclk);
        checkOutput("rd_wait1", 32'(m_hready[2]), 32'h0);
        nextCycle();
        @(negedge hclk);
        checkOutput("rd_wait2", 32'(m_hready[2]), 32'h0);
        nextCycle();
        s_hreadyout[6] = 1'b1;
        @(negedge hclk);
        checkOutput("rd_done", 32'(m_hready[2]), 32'h1);
        checkOutput("rd_hrdata", m_hrdata[2], 32'h1234_5678);
        nextCycle();
        s_hrdata[6] = 32'h0;

        // Master 1 hits the default slave: two-cycle ERROR.
        applyStimulus(1, T_NONSEQ, 32'hF000_0000, 1'b0, 32'h0);
        @(negedge hclk);
        checkOutput("ds_stall", 32'(m_hready[1]), 32'h0);
        nextCycle();
        @(negedge hclk);
        checkOutput("ds_nosel", 32'(s_hsel), 32'h0);
        checkOutput("ds_hready_a", 32'(m_hready[1]), 32'h1);
        nextCycle();
        applyStimulus(1, T_IDLE, 32'h0, 1'b0, 32'h0);
        @(negedge hclk);
        checkOutput("ds_nosel2", 32'(s_hsel), 32'h0);
        checkOutput("ds_err1_rdy", 32'(m_hready[1]), 32'h0);
        checkOutput("ds_err1_resp", 32'(m_hresp[1]), 32'h1);
        nextCycle();
        @(negedge hclk);
        checkOutput("ds_err2_rdy", 32'(m_hready[1]), 32'h1);
        checkOutput("ds_err2_resp", 32'(m_hresp[1]), 32'h1);
        nextCycle();
        @(negedge hclk);
        checkOutput("ds_after_resp", 32'(m_hresp[1]), 32'h0);
        nextCycle();

        // Master 0 INCR4 burst holds the bus while master 3 waits.
        m_hburst[0] = 3'b011;
        applyStimulus(0, T_NONSEQ, 32'h2000_0000, 1'b1, 32'h0);
        @(negedge hclk);
        checkOutput("bu_req_stall", 32'(m_hready[0]), 32'h0);
        nextCycle();
        applyStimulus(3, T_NONSEQ, 32'h3000_0000, 1'b0, 32'h0);
        for (int b = 0; b < 4; b++) begin
            if (b > 0) applyStimulus(0, T_SEQ, 32'h2000_0000 + 32'(4 * b), 1'b1, 32'(b));
            @(negedge hclk);
            checkOutput("bu_hsel", 32'(s_hsel), 32'h04);
            checkOutput("bu_m0_ready", 32'(m_hready[0]), 32'h1);
            checkOutput("bu_m3_stall", 32'(m_hready[3]), 32'h0);
            nextCycle();
        end
        m_hburst[0] = 3'b000;
        applyStimulus(0, T_IDLE, 32'h0, 1'b0, 32'h0);
        @(negedge hclk);
        checkOutput("bu_m3_stall_last", 32'(m_hready[3]), 32'h0);
        nextCycle();
        @(negedge hclk);
        checkOutput("bu_m3_hsel", 32'(s_hsel), 32'h08);
        checkOutput("bu_m3_ready", 32'(m_hready[3]), 32'h1);
        checkOutput("bu_m3_haddr", s_haddr[0], 32'h3000_0000);
        nextCycle();
        applyStimulus(3, T_IDLE, 32'h0, 1'b0, 32'h0);
        @(negedge hclk);
        checkOutput("bu_m3_data", 32'(m_hready[3]), 32'h1);
        nextCycle();

        // Reset pulse during a slave wait state.
        applyStimulus(3, T_NONSEQ, 32'h5000_0000, 1'b0, 32'h0);
        @(negedge hclk);
        checkOutput("rw_hsel", 32'(s_hsel), 32'h20);
        nextCycle();
        applyStimulus(3, T_IDLE, 32'h0, 1'b0, 32'h0);
        applyStimulus(0, T_NONSEQ, 32'h4000_0000, 1'b0, 32'h0);
        s_hreadyout[5] = 1'b0;
        s_hresp[5] = 1'b1;
        s_hrdata[5] = 32'hBAD0_BAD0;
        @(negedge hclk);
        checkOutput("rw_wait", 32'(m_hready[3]), 32'h0);
        checkOutput("rw_wait_resp", 32'(m_hresp[3]), 32'h1);
        checkOutput("rw_m0_stall", 32'(m_hready[0]), 32'h0);
        #1;
        hreset_n = 1'b0;
        #1;
        checkOutput("rw_rst_readyin", 32'(s_hreadyin[0]), 32'h1);
        checkOutput("rw_rst_m3_ready", 32'(m_hready[3]), 32'h1);
        checkOutput("rw_rst_hresp", 32'(m_hresp), 32'h0);
        checkOutput("rw_rst_hrdata", m_hrdata[3], 32'h0);
        checkOutput("rw_rst_hsel", 32'(s_hsel), 32'h10);
        checkOutput("rw_rst_m0_ready", 32'(m_hready[0]), 32'h1);
        nextCycle();
        hreset_n = 1'b1;
        s_hreadyout = '1;
        s_hresp = '0;
        @(negedge hclk);
        checkOutput("rw_post_hsel", 32'(s_hsel), 32'h10);
        checkOutput("rw_post_ready", 32'(m_hready[0]), 32'h1);
        nextCycle();
        applyStimulus(0, T_IDLE, 32'h0, 1'b0, 32'h0);
        @(negedge hclk);
        checkOutput("rw_post_data", 32'(m_hready[0]), 32'h1);
        nextCycle();

        // Request rounds: the first has all four masters, the rest are random subsets.
        owner_m = 0;
        for (int r = 0; r < 25; r++) begin
            mask = (r == 0) ? 4'hF : 4'($urandom_range(1, 15));
            exp_q.delete();
            got_q.delete();
            for (int off = 0; off < MAS; off++) begin
                if (mask[(owner_m + off) % MAS]) exp_q.push_back((owner_m + off) % MAS);
            end
            pending = 0;
            for (int i = 0; i < MAS; i++) begin
                st[i] = 0;
                if (mask[i]) begin
                    st[i] = 1;
                    ad[i] = $urandom() & 32'hF000_0FFC;
                    wr[i] = 1'($urandom_range(0, 1));
                    wd[i] = $urandom();
                    applyStimulus(i, T_NONSEQ, ad[i], wr[i], $urandom());
                    pending++;
                end
            end
            cyc = 0;
            while (pending > 0 && cyc < 200) begin
                for (int k = 0; k < SLV; k++) begin
                    s_hreadyout[k] = ($urandom_range(0, 3) != 0);
                    s_hrdata[k] = $urandom();
                    s_hresp[k] = ($urandom_range(0, 7) == 0);
                end
                @(negedge hclk);
                for (int i = 0; i < MAS; i++) begin
                    acc[i] = 1'b0;
                    fin[i] = 1'b0;
                    sl = int'(ad[i][31:28]);
                    if (st[i] == 2 && m_hready[i]) begin
                        if (wr[i]) checkOutput("rr_wdata", s_hwdata[0], wd[i]);
                        else checkOutput("rr_rdata", m_hrdata[i], (sl >= SLV) ? 32'h0 : s_hrdata[sl]);
                        checkOutput("rr_resp", 32'(m_hresp[i]), (sl >= SLV) ? 32'h1 : 32'(s_hresp[sl]));
                        fin[i] = 1'b1;
                    end else if (st[i] == 1 && m_hready[i]) begin
                        checkOutput("rr_hsel", 32'(s_hsel), (sl >= SLV) ? 32'h0 : (32'h1 << sl));
                        got_q.push_back(i);
                        acc[i] = 1'b1;
                    end
                end
                nextCycle();
                cyc++;
                for (int i = 0; i < MAS; i++) begin
                    if (acc[i]) begin
                        st[i] = 2;
                        applyStimulus(i, T_IDLE, ad[i], wr[i], wd[i]);
                    end else if (fin[i]) begin
                        st[i] = 0;
                        pending--;
                        applyStimulus(i, T_IDLE, 32'h0, 1'b0, $urandom());
                    end
                end
            end
            checkOutput("rr_done", 32'(pending), 32'h0);
            checkOutput("rr_count", 32'(got_q.size()), 32'(exp_q.size()));
            for (int j = 0; j < exp_q.size(); j++) begin
                checkOutput("rr_order", (j < got_q.size()) ? 32'(got_q[j]) : 32'hFFFF_FFFF, 32'(exp_q[j]));
            end
            if (exp_q.size() > 0) owner_m = exp_q[exp_q.size() - 1];
            for (int i = 0; i < MAS; i++) applyStimulus(i, T_IDLE, 32'h0, 1'b0, 32'h0);
            s_hreadyout = '1;
            s_hresp = '0;
            nextCycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
